writeback_unit: RTL
===================

WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 SHALL have parameter DEPTH, default 4, result-queue entries (power of two, 2..16).
REQ-002 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port issueValid  input  1  an instruction with a destination register issued this cycle.
REQ-005 SHALL have port issueReg  input  5  destination register of the issued instruction.
REQ-006 SHALL have port resultValid  input  1  producer offers a completed result.
REQ-007 SHALL have port resultReady  output  1  unit accepts the result this cycle.
REQ-008 SHALL have port resultReg  input  5  destination register of the offered result.
REQ-009 SHALL have port resultData  input  32  value to write back.
REQ-010 SHALL have port rfWriteEnable  output  1  register-file write strobe, registered.
REQ-011 SHALL have port rfWriteReg  output  5  register-file write index, registered.
REQ-012 SHALL have port rfWriteData  output  32  register-file write data, registered.
REQ-013 SHALL have port pendingMask  output  32  scoreboard; bit n set = register n awaiting write-back.
REQ-014 SHALL have port fifoCount  output  clog2(DEPTH)+1  current queue occupancy.
REQ-015 SHALL have port orphanError  output  1  sticky flag, result for a non-pending register.

Function
REQ-016 Result accepted at a rising edge where resultValid and resultReady both high; entry {resultReg, resultData} pushed at FIFO tail.
REQ-017 resultReady SHALL equal (fifoCount != DEPTH), decoded from registered count only; a same-cycle pop does not free space for a push.
REQ-018 With resultValid high and resultReady low, no push; producer holds resultReg/resultData stable until accepted.
REQ-019 Each edge with fifoCount > 0 SHALL pop the head entry; exactly one pop per cycle maximum.
REQ-020 Popped entry with reg != 0: at that edge rfWriteEnable<=1, rfWriteReg<=reg, rfWriteData<=data; held for exactly one cycle.
REQ-021 Popped entry with reg == 0: consumes the drain slot, rfWriteEnable<=0, rfWriteReg/rfWriteData unchanged.
REQ-022 Edge with no pop: rfWriteEnable<=0; rfWriteReg/rfWriteData retain prior values.
REQ-023 Latency: result accepted at edge k into an empty queue SHALL produce rfWriteEnable high from edge k+1 to edge k+2; queued results drain strictly in acceptance order.
REQ-024 Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
REQ-025 Scoreboard: edge with issueValid and issueReg != 0 SHALL set pendingMask[issueReg]; issueReg == 0 ignored.
REQ-026 Scoreboard: pop of entry with reg r != 0 SHALL clear pendingMask[r] at the same edge rfWriteEnable rises.
REQ-027 Same edge set and clear of the same register: set wins (bit remains 1).
REQ-028 pendingMask[0] SHALL be constant 0.
REQ-029 Acceptance of a result with resultReg != 0 whose pendingMask bit is 0 at that edge SHALL set orphanError; entry is still queued and written; orphanError stays 1 until reset.
REQ-030 fifoCount SHALL equal pushes minus pops since reset, range 0..DEPTH.

Reset
REQ-031 reset high SHALL immediately, without clock, force: fifoCount=0, pointers=0, pendingMask=0, rfWriteEnable=0, rfWriteReg=0, rfWriteData=0, orphanError=0; resultReady=1 follows.
REQ-032 Reset during operation SHALL discard all queued entries; no rfWriteEnable pulse for them after reset release.
REQ-033 First edge after reset deassertion SHALL accept a push and scoreboard update normally.

Verification
REQ-034 Issue reg 5, then result {5, 0xDEADBEEF} accepted at edge k -> rfWriteEnable=1, rfWriteReg=5, rfWriteData=0xDEADBEEF during k+1..k+2; pendingMask[5] 1 until edge k+1 then 0.
REQ-035 Issue regs 1-4, push 4 results back-to-back while writes happen -> fill/drain order 1,2,3,4 preserved; then with drain forced full (DEPTH pushes consecutive, each edge push+pop), fifoCount never exceeds DEPTH, resultReady low only when count=DEPTH.
REQ-036 Result {0, 0x12345678} -> fifoCount rises then falls, no rfWriteEnable pulse, pendingMask unchanged, orphanError stays 0.
REQ-037 Issue reg 7 same edge as popping pending write to reg 7 -> rfWriteEnable pulses with reg 7, pendingMask[7] remains 1.
REQ-038 Result {9, x} with pendingMask[9]=0 -> orphanError=1, write to 9 still occurs, flag persists until reset.
REQ-039 Three entries queued, reset asserted mid-cycle -> all outputs zero immediately, fifoCount=0, no write pulses after release.

Source files
------------

// File: rtl/writeback_unit.sv
// Write-back stage: queues completed results, drains one per cycle into the
// register file, and tracks which registers still await their result.
module writeback_unit #(
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     issueValid,
  input  logic [4:0]               issueReg,
  input  logic                     resultValid,
  output logic                     resultReady,
  input  logic [4:0]               resultReg,
  input  logic [31:0]              resultData,
  output logic                     rfWriteEnable,
  output logic [4:0]               rfWriteReg,
  output logic [31:0]              rfWriteData,
  output logic [31:0]              pendingMask,
  output logic [$clog2(DEPTH):0]   fifoCount,
  output logic                     orphanError
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic [4:0]    r_fifoReg  [DEPTH];
  logic [31:0]   r_fifoData [DEPTH];
  logic [31:0]   r_pending;
  logic          r_orphan;
  logic          r_we;
  logic [4:0]    r_wreg;
  logic [31:0]   r_wdata;

  logic          w_push;
  logic          w_pop;
  logic [4:0]    w_headReg;
  logic [31:0]   w_headData;
  logic          w_headWrites;
  logic [31:0]   w_setMask;
  logic [31:0]   w_clearMask;
  logic [31:0]   w_pendingNext;
  logic [CW-1:0] w_countNext;
  logic          w_orphanHit;

  // Ready comes only from the registered count, so a pop never frees a slot early.
  assign resultReady  = (r_count != CW'(DEPTH));
  assign w_push       = resultValid & resultReady;
  assign w_pop        = (r_count != {CW{1'b0}});
  assign w_headReg    = r_fifoReg[r_head];
  assign w_headData   = r_fifoData[r_head];
  assign w_headWrites = w_pop & (w_headReg != 5'd0);
  assign w_orphanHit  = w_push & (resultReg != 5'd0) & ~r_pending[resultReg];

  // Scoreboard next state: clear on write-back, then set on issue so set wins.
  always_comb begin
    w_setMask     = 32'd0;
    w_clearMask   = 32'd0;
    if (issueValid && issueReg != 5'd0) begin
      w_setMask = 32'd1 << issueReg;
    end else begin
      w_setMask = 32'd0;
    end
    if (w_headWrites) begin
      w_clearMask = 32'd1 << w_headReg;
    end else begin
      w_clearMask = 32'd0;
    end
    w_pendingNext = ((r_pending & ~w_clearMask) | w_setMask) & ~32'd1;
  end

  // Occupancy next state; push and pop together leave it unchanged.
  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + CW'(1);
      2'b01:   w_countNext = r_count - CW'(1);
      default: w_countNext = r_count;
    endcase
  end

  // Queue storage; contents beyond the pointers are don't-care, so no reset.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifoReg[r_tail]  <= resultReg;
      r_fifoData[r_tail] <= resultData;
    end
  end

  // Pointers, occupancy, scoreboard and sticky orphan flag.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_head    <= {PW{1'b0}};
      r_tail    <= {PW{1'b0}};
      r_count   <= {CW{1'b0}};
      r_pending <= 32'd0;
      r_orphan  <= 1'b0;
    end else begin
      if (w_push) begin
        r_tail <= r_tail + PW'(1);
      end
      if (w_pop) begin
        r_head <= r_head + PW'(1);
      end
      r_count   <= w_countNext;
      r_pending <= w_pendingNext;
      if (w_orphanHit) begin
        r_orphan <= 1'b1;
      end
    end
  end

  // Register-file write port; a register-0 entry burns the slot without a strobe.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_we    <= 1'b0;
      r_wreg  <= 5'd0;
      r_wdata <= 32'd0;
    end else begin
      r_we <= w_headWrites;
      if (w_headWrites) begin
        r_wreg  <= w_headReg;
        r_wdata <= w_headData;
      end
    end
  end

  assign rfWriteEnable = r_we;
  assign rfWriteReg    = r_wreg;
  assign rfWriteData   = r_wdata;
  assign pendingMask   = r_pending;
  assign fifoCount     = r_count;
  assign orphanError   = r_orphan;

endmodule
